// File: rtl/weight_rb_pkg.sv
// rtl/weight_rb_pkg.sv - shared types and index-width helpers for the weight ring buffer
package weight_rb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rb_state_e;

    localparam int BANK_MU  = 0;
    localparam int BANK_VAR = 1;
    localparam int PASS_W   = 8;

    // Index width that never collapses to zero bits for single-entry dimensions.
    function automatic int rb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rb_bank_mem.sv
// rtl/rb_bank_mem.sv - one bank: DEPTH x LANES words, per-lane write, registered read
module rb_bank_mem
    import weight_rb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANES  = 8,
    parameter int DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [rb_idx_w(LANES)-1:0]  wr_lane,
    input  logic [rb_idx_w(DEPTH)-1:0]  wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        rd_en,
    input  logic [rb_idx_w(DEPTH)-1:0]  rd_addr,
    output logic [LANES*DATA_W-1:0]     rd_data
);

    localparam int LW = rb_idx_w(LANES);

    logic [LANES*DATA_W-1:0] mem [DEPTH];
    logic [LANES*DATA_W-1:0] rd_data_d;
    logic [LANES*DATA_W-1:0] rd_data_q;

    // Storage has no reset so weights survive a mid-stream reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (wr_en && (wr_lane == LW'(k))) begin
                mem[wr_addr][k*DATA_W +: DATA_W] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // The read register doubles as the output data register; it holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/weight_ring_buffer.sv
// rtl/weight_ring_buffer.sv - multi-bank circular weight streamer; RB_WRAP_CNT_EN adds wrap_count
module weight_ring_buffer
    import weight_rb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANES  = 8,
    parameter int DEPTH  = 8,
    parameter int NBANK  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [rb_idx_w(NBANK)-1:0]  wr_bank,
    input  logic [rb_idx_w(LANES)-1:0]  wr_lane,
    input  logic [rb_idx_w(DEPTH)-1:0]  wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        wr_err,
    input  logic                        start,
    input  logic [rb_idx_w(NBANK)-1:0]  bank_sel,
    input  logic [PASS_W-1:0]           num_passes,
    input  logic                        stop,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_W-1:0]     out_data,
    output logic [rb_idx_w(DEPTH)-1:0]  out_idx,
    output logic [rb_idx_w(NBANK)-1:0]  out_bank,
    output logic                        out_last,
    output logic                        busy
`ifdef RB_WRAP_CNT_EN
    ,
    output logic [15:0]                 wrap_count
`endif
);

    localparam int BW = rb_idx_w(NBANK);
    localparam int AW = rb_idx_w(DEPTH);

    rb_state_e         state_d, state_q;
    logic              out_valid_d, out_valid_q;
    logic [AW-1:0]     out_idx_d, out_idx_q;
    logic [BW-1:0]     out_bank_d, out_bank_q;
    logic              out_last_d, out_last_q;
    logic [PASS_W-1:0] pass_d, pass_q;
    logic [PASS_W-1:0] passes_d, passes_q;
    logic              wr_err_d, wr_err_q;

    logic              mem_we;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic              handshake;
    logic              wrap;
    logic [AW-1:0]     nxt_idx;
    logic [PASS_W-1:0] nxt_pass;
    logic [LANES*DATA_W-1:0] rd_data [NBANK];

    assign handshake = out_valid_q && out_ready;
    assign wrap      = (out_idx_q == AW'(DEPTH - 1));
    assign nxt_idx   = out_idx_q + AW'(1);
    assign nxt_pass  = (wrap && (pass_q != {PASS_W{1'b1}})) ? pass_q + PASS_W'(1) : pass_q;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_bank_d  = out_bank_q;
        out_last_d  = out_last_q;
        pass_d      = pass_q;
        passes_d    = passes_q;
        wr_err_d    = 1'b0;
        mem_we      = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = out_idx_q;
        case (state_q)
            IDLE: begin
                mem_we = wr_en;
                if (start && !stop) begin
                    state_d     = STREAM;
                    out_valid_d = 1'b1;
                    out_idx_d   = '0;
                    out_bank_d  = bank_sel;
                    out_last_d  = 1'b0;
                    pass_d      = '0;
                    passes_d    = num_passes;
                    rd_en       = 1'b1;
                    rd_addr     = '0;
                end
            end
            STREAM: begin
                wr_err_d = wr_en;
                if (stop || (handshake && out_last_q)) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_idx_d   = '0;
                    out_last_d  = 1'b0;
                    pass_d      = '0;
                end else if (handshake) begin
                    out_idx_d  = nxt_idx;
                    pass_d     = nxt_pass;
                    // Bank changes only on a pass boundary so a pass is never mixed.
                    if (wrap) begin
                        out_bank_d = bank_sel;
                    end
                    out_last_d = (passes_q != '0) && (nxt_idx == AW'(DEPTH - 1)) &&
                                 (nxt_pass == passes_q - PASS_W'(1));
                    rd_en      = 1'b1;
                    rd_addr    = nxt_idx;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_bank_q  <= BW'(BANK_MU);
            out_last_q  <= 1'b0;
            pass_q      <= '0;
            passes_q    <= '0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_bank_q  <= out_bank_d;
            out_last_q  <= out_last_d;
            pass_q      <= pass_d;
            passes_q    <= passes_d;
            wr_err_q    <= wr_err_d;
        end
    end

    // Exact bank match also drops writes to nonexistent banks when NBANK is not a power of two.
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        rb_bank_mem #(
            .DATA_W (DATA_W),
            .LANES  (LANES),
            .DEPTH  (DEPTH)
        ) u_mem (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (mem_we && (wr_bank == BW'(b))),
            .wr_lane (wr_lane),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_en   (rd_en),
            .rd_addr (rd_addr),
            .rd_data (rd_data[b])
        );
    end

    always_comb begin
        out_data = '0;
        for (int b = 0; b < NBANK; b++) begin
            if (out_bank_q == BW'(b)) begin
                out_data = rd_data[b];
            end
        end
    end

`ifdef RB_WRAP_CNT_EN
    logic [15:0] wrap_cnt_d, wrap_cnt_q;

    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if ((state_q == IDLE) && start && !stop) begin
            wrap_cnt_d = '0;
        end else if ((state_q == STREAM) && !stop && handshake && wrap) begin
            wrap_cnt_d = wrap_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_cnt_q <= '0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign wrap_count = wrap_cnt_q;
`endif

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_bank  = out_bank_q;
    assign out_last  = out_last_q;
    assign wr_err    = wr_err_q;
    assign busy      = (state_q == STREAM);

endmodule

// File: tb/tb_weight_ring_buffer.sv
// tb/tb_weight_ring_buffer.sv - directed self-checking bench for weight_ring_buffer
module tb_weight_ring_buffer;

    logic         clk;
    logic         rst;
    logic         wr_en;
    logic [0:0]   wr_bank;
    logic [2:0]   wr_lane;
    logic [2:0]   wr_addr;
    logic [15:0]  wr_data;
    logic         wr_err;
    logic         start;
    logic [0:0]   bank_sel;
    logic [7:0]   num_passes;
    logic         stop;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [2:0]   out_idx;
    logic [0:0]   out_bank;
    logic         out_last;
    logic         busy;
`ifdef RB_WRAP_CNT_EN
    logic [15:0]  wrap_count;
`endif

    int n_pass;
    int n_total;

    weight_ring_buffer #(
        .DATA_W (16),
        .LANES  (8),
        .DEPTH  (8),
        .NBANK  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_lane    (wr_lane),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_err     (wr_err),
        .start      (start),
        .bank_sel   (bank_sel),
        .num_passes (num_passes),
        .stop       (stop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_bank   (out_bank),
        .out_last   (out_last),
        .busy       (busy)
`ifdef RB_WRAP_CNT_EN
        ,
        .wrap_count (wrap_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] exp_beat(input int bank, input int e);
        logic [127:0] r;
        r = '0;
        for (int l = 0; l < 8; l++) begin
            r[l*16 +: 16] = ((bank != 0) ? 16'h2000 : 16'h1000) + 16'(8*l + e);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [0:0] bank, input logic [7:0] passes);
        bank_sel   = bank;
        num_passes = passes;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic load_all();
        wr_en = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int l = 0; l < 8; l++) begin
                for (int e = 0; e < 8; e++) begin
                    wr_bank = 1'(b);
                    wr_lane = 3'(l);
                    wr_addr = 3'(e);
                    wr_data = ((b != 0) ? 16'h2000 : 16'h1000) + 16'(8*l + e);
                    tick();
                end
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (out_last !== 1'b0 || wr_err !== 1'b0) $display("FAIL reset_last_err: got %b%b want 00", out_last, wr_err); else n_pass++;
        n_total++; if (out_idx !== 3'd0 || out_bank !== 1'b0) $display("FAIL reset_idx_bank: got %0d/%0d want 0/0", out_idx, out_bank); else n_pass++;
        n_total++; if (out_data !== 128'd0) $display("FAIL reset_data: got %h want 0", out_data); else n_pass++;
    endtask

    task automatic test_single_pass();
        out_ready = 1'b1;
        pulse_start(1'b0, 8'd1);
        for (int b = 0; b < 8; b++) begin
            n_total++; if (out_valid !== 1'b1 || busy !== 1'b1) $display("FAIL t1_valid beat %0d: got %b%b want 11", b, out_valid, busy); else n_pass++;
            n_total++; if (out_idx !== 3'(b)) $display("FAIL t1_idx beat %0d: got %0d want %0d", b, out_idx, b); else n_pass++;
            n_total++; if (out_data !== exp_beat(0, b)) $display("FAIL t1_data beat %0d: got %h want %h", b, out_data, exp_beat(0, b)); else n_pass++;
            n_total++; if (out_last !== (b == 7)) $display("FAIL t1_last beat %0d: got %b want %b", b, out_last, (b == 7)); else n_pass++;
            if (b == 5) begin
                n_total++; if (out_data[3*16 +: 16] !== 16'h101D) $display("FAIL t1_lane3_beat5: got %h want 101d", out_data[3*16 +: 16]); else n_pass++;
            end
            tick();
        end
        n_total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL t1_end_idle: got %b%b want 00", out_valid, busy); else n_pass++;
    endtask

    task automatic test_backpressure();
        int k;
        k = 0;
        pulse_start(1'b0, 8'd2);
        for (int cyc = 0; cyc < 80 && k < 16; cyc++) begin
            out_ready = (cyc % 2 == 0);
            n_total++; if (out_valid !== 1'b1) $display("FAIL t2_valid beat %0d: got %b want 1", k, out_valid); else n_pass++;
            n_total++; if (out_idx !== 3'(k % 8) || out_data !== exp_beat(0, k % 8)) $display("FAIL t2_beat %0d: got idx %0d data %h want idx %0d", k, out_idx, out_data, k % 8); else n_pass++;
            n_total++; if (out_last !== (k == 15)) $display("FAIL t2_last beat %0d: got %b want %b", k, out_last, (k == 15)); else n_pass++;
            tick();
            if (out_ready) k++;
        end
        out_ready = 1'b1;
        n_total++; if (k !== 16) $display("FAIL t2_beat_count: got %0d want 16", k); else n_pass++;
        n_total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL t2_end_idle: got %b%b want 00", out_valid, busy); else n_pass++;
    endtask

    task automatic test_bank_switch_stop();
        out_ready = 1'b1;
        pulse_start(1'b0, 8'd0);
        for (int n = 0; n < 12; n++) begin
            n_total++; if (out_bank !== 1'(n / 8) || out_idx !== 3'(n % 8)) $display("FAIL t3_bank_idx beat %0d: got %0d/%0d want %0d/%0d", n, out_bank, out_idx, n / 8, n % 8); else n_pass++;
            n_total++; if (out_data !== exp_beat(n / 8, n % 8) || out_last !== 1'b0) $display("FAIL t3_data beat %0d: got %h last %b want %h last 0", n, out_data, out_last, exp_beat(n / 8, n % 8)); else n_pass++;
            if (n == 8) begin
                n_total++; if (out_data[15:0] !== 16'h2000) $display("FAIL t3_wrap_lane0: got %h want 2000", out_data[15:0]); else n_pass++;
            end
            if (n == 4) bank_sel = 1'b1;
            if (n == 11) stop = 1'b1;
            tick();
        end
        stop     = 1'b0;
        bank_sel = 1'b0;
        n_total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL t3_stop_idle: got %b%b want 00", out_valid, busy); else n_pass++;
        n_total++; if (out_idx !== 3'd0) $display("FAIL t3_stop_ptr: got %0d want 0", out_idx); else n_pass++;
    endtask

    task automatic test_write_in_stream();
        out_ready = 1'b1;
        pulse_start(1'b1, 8'd2);
        wr_bank = 1'b1;
        wr_lane = 3'd0;
        wr_addr = 3'd2;
        wr_data = 16'hDEAD;
        for (int n = 0; n < 16; n++) begin
            wr_en = (n == 0);
            n_total++; if (out_idx !== 3'(n % 8) || out_data !== exp_beat(1, n % 8)) $display("FAIL t4_beat %0d: got idx %0d data %h want %h", n, out_idx, out_data, exp_beat(1, n % 8)); else n_pass++;
            if (n == 1) begin
                n_total++; if (wr_err !== 1'b1) $display("FAIL t4_wr_err_pulse: got %b want 1", wr_err); else n_pass++;
            end
            if (n == 2) begin
                n_total++; if (wr_err !== 1'b0) $display("FAIL t4_wr_err_clear: got %b want 0", wr_err); else n_pass++;
            end
            tick();
        end
        wr_en = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL t4_end_idle: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid_stream();
        out_ready = 1'b1;
        pulse_start(1'b1, 8'd1);
        tick();
        tick();
        tick();
        n_total++; if (out_idx !== 3'd3 || busy !== 1'b1) $display("FAIL t5_pre_reset: got idx %0d busy %b want 3/1", out_idx, busy); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) $display("FAIL t5_rst_flags: got %b%b%b want 000", out_valid, busy, out_last); else n_pass++;
        n_total++; if (out_idx !== 3'd0 || out_bank !== 1'b0 || out_data !== 128'd0) $display("FAIL t5_rst_outputs: got %0d/%0d/%h want 0", out_idx, out_bank, out_data); else n_pass++;
        pulse_start(1'b1, 8'd1);
        for (int n = 0; n < 8; n++) begin
            n_total++; if (out_idx !== 3'(n) || out_data !== exp_beat(1, n)) $display("FAIL t5_restart beat %0d: got idx %0d data %h want %h", n, out_idx, out_data, exp_beat(1, n)); else n_pass++;
            tick();
        end
        n_total++; if (busy !== 1'b0) $display("FAIL t5_end_idle: got %b want 0", busy); else n_pass++;
    endtask

`ifdef RB_WRAP_CNT_EN
    task automatic test_wrap_count();
        out_ready = 1'b1;
        pulse_start(1'b0, 8'd3);
        n_total++; if (wrap_count !== 16'd0) $display("FAIL t6_start_zero: got %0d want 0", wrap_count); else n_pass++;
        for (int n = 0; n < 24; n++) tick();
        n_total++; if (wrap_count !== 16'd3 || busy !== 1'b0) $display("FAIL t6_count: got %0d busy %b want 3/0", wrap_count, busy); else n_pass++;
        pulse_start(1'b0, 8'd1);
        n_total++; if (wrap_count !== 16'd0) $display("FAIL t6_restart_clear: got %0d want 0", wrap_count); else n_pass++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask
`endif

    task automatic test_idle_controls();
        out_ready  = 1'b1;
        stop       = 1'b1;
        bank_sel   = 1'b0;
        num_passes = 8'd1;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        stop       = 1'b0;
        n_total++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL idle_stop_beats_start: got %b%b want 00", busy, out_valid); else n_pass++;
        wr_en   = 1'b1;
        wr_bank = 1'b0;
        wr_lane = 3'd0;
        wr_addr = 3'd0;
        wr_data = 16'hBEEF;
        pulse_start(1'b0, 8'd1);
        wr_en = 1'b0;
        n_total++; if (out_data[15:0] !== 16'h1000 || wr_err !== 1'b0) $display("FAIL collide_old_data: got %h err %b want 1000 err 0", out_data[15:0], wr_err); else n_pass++;
        for (int n = 0; n < 8; n++) tick();
        pulse_start(1'b0, 8'd1);
        n_total++; if (out_data[15:0] !== 16'hBEEF) $display("FAIL collide_committed: got %h want beef", out_data[15:0]); else n_pass++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_bank    = 1'b0;
        wr_lane    = 3'd0;
        wr_addr    = 3'd0;
        wr_data    = 16'd0;
        start      = 1'b0;
        bank_sel   = 1'b0;
        num_passes = 8'd0;
        stop       = 1'b0;
        out_ready  = 1'b0;
        test_reset();
        load_all();
        test_single_pass();
        test_backpressure();
        test_bank_switch_stop();
        test_write_in_stream();
        test_reset_mid_stream();
`ifdef RB_WRAP_CNT_EN
        test_wrap_count();
`endif
        test_idle_controls();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
